// File: rtl/dsp_pack_pkg.sv
// Shared definitions for the INT8 dual-product packing path: lane/field geometry
// and the decoded lane-pair type.
package dsp_pack_pkg;

  localparam int LANE_W = 16;
  localparam int PACK_W = 48;
  localparam int LO_LSB = 0;
  localparam int HI_LSB = 16;

  typedef struct packed {
    logic signed [LANE_W-1:0] hi;
    logic signed [LANE_W-1:0] lo;
  } lane_pair_t;

endpackage

// File: rtl/dsp_pack_decode.sv
// Splits one packed a*c*2^16 + b*c product into its two signed 16-bit lane products.
// Purely combinational; the upper 16 bits of the DSP result carry no information.
module dsp_pack_decode
  import dsp_pack_pkg::*;
(
  input  logic [PACK_W-1:0] p,
  output lane_pair_t        lanes
);

  logic signed [LANE_W-1:0] lo_raw;
  logic signed [LANE_W-1:0] hi_raw;
  logic                     unused_upper;

  assign lo_raw = p[LO_LSB +: LANE_W];
  assign hi_raw = p[HI_LSB +: LANE_W];

  // A negative low product borrowed one from the high field; give it back.
  assign lanes.lo = lo_raw;
  assign lanes.hi = hi_raw + {{(LANE_W-1){1'b0}}, lo_raw[LANE_W-1]};

  assign unused_upper = ^p[PACK_W-1:HI_LSB+LANE_W];

endmodule

// File: rtl/dsp_packed_acc_unpack.sv
// Decodes packed dual INT8 products and accumulates both lanes per s_last-terminated
// group. Define DSP_PACK_SAT_EN to clamp accumulators and report m_sat instead of wrapping.
module dsp_packed_acc_unpack
  import dsp_pack_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [PACK_W-1:0]       s_p,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [ACC_W-1:0] m_acc_hi,
  output logic signed [ACC_W-1:0] m_acc_lo,
  output logic [CNT_W-1:0]        m_beats,
  output logic                    m_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef struct packed {
    logic                    sat;
    logic signed [ACC_W-1:0] val;
  } acc_res_t;

  function automatic acc_res_t acc_add(input logic signed [ACC_W-1:0] acc,
                                       input logic signed [LANE_W-1:0] x);
    acc_res_t r;
`ifdef DSP_PACK_SAT_EN
    logic signed [ACC_W:0] sum;
    sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-LANE_W){x[LANE_W-1]}}, x};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      r.sat = 1'b1;
      r.val = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      r.sat = 1'b0;
      r.val = sum[ACC_W-1:0];
    end
`else
    r.sat = 1'b0;
    r.val = acc + {{(ACC_W-LANE_W){x[LANE_W-1]}}, x};
`endif
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  lane_pair_t lanes;
  acc_res_t   nxt_hi;
  acc_res_t   nxt_lo;
  logic       take;
  logic       nxt_sat;
  logic [CNT_W-1:0] nxt_cnt;

  logic signed [ACC_W-1:0] acc_hi_p0;
  logic signed [ACC_W-1:0] acc_lo_p0;
  logic [CNT_W-1:0]        cnt_p0;
  logic                    sat_p0;

  logic                    vld_p1;
  logic signed [ACC_W-1:0] acc_hi_p1;
  logic signed [ACC_W-1:0] acc_lo_p1;
  logic [CNT_W-1:0]        cnt_p1;
  logic                    sat_p1;

  dsp_pack_decode u_decode (
    .p     (s_p),
    .lanes (lanes)
  );

  assign s_ready = !rst && (!vld_p1 || m_ready);
  assign take    = s_valid && s_ready;
  assign nxt_hi  = acc_add(acc_hi_p0, lanes.hi);
  assign nxt_lo  = acc_add(acc_lo_p0, lanes.lo);
  assign nxt_sat = sat_p0 || nxt_hi.sat || nxt_lo.sat;
  assign nxt_cnt = cnt_inc(cnt_p0);

  // Stage p0: running group accumulation, cleared when the group folds into p1.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hi_p0 <= '0;
      acc_lo_p0 <= '0;
      cnt_p0    <= '0;
      sat_p0    <= 1'b0;
    end else if (take) begin
      if (s_last) begin
        acc_hi_p0 <= '0;
        acc_lo_p0 <= '0;
        cnt_p0    <= '0;
        sat_p0    <= 1'b0;
      end else begin
        acc_hi_p0 <= nxt_hi.val;
        acc_lo_p0 <= nxt_lo.val;
        cnt_p0    <= nxt_cnt;
        sat_p0    <= nxt_sat;
      end
    end
  end

  // Stage p1: held group result; reloads in the same cycle it is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      acc_hi_p1 <= '0;
      acc_lo_p1 <= '0;
      cnt_p1    <= '0;
      sat_p1    <= 1'b0;
    end else if (take && s_last) begin
      vld_p1    <= 1'b1;
      acc_hi_p1 <= nxt_hi.val;
      acc_lo_p1 <= nxt_lo.val;
      cnt_p1    <= nxt_cnt;
      sat_p1    <= nxt_sat;
    end else if (vld_p1 && m_ready) begin
      vld_p1    <= 1'b0;
    end
  end

  assign m_valid  = vld_p1;
  assign m_acc_hi = acc_hi_p1;
  assign m_acc_lo = acc_lo_p1;
  assign m_beats  = cnt_p1;
`ifdef DSP_PACK_SAT_EN
  assign m_sat    = sat_p1;
`else
  assign m_sat    = 1'b0;
`endif

endmodule
